// File: rtl/rs232_avalon_slave.sv
// rs232_avalon_slave - Avalon-MM slave UART (8N1), feeds the RSA wrapper.
//
// Register map (byte addresses):
//   0x0 RX     (R)  {24'b0, rx byte}; completing the read clears rx_ok, overrun, ferr
//   0x4 TX     (W)  bits [7:0] start a frame if tx_ok=1, otherwise dropped
//   0x8 STATUS (R)  bit7 rx_ok, bit6 tx_ok, bit1 overrun, bit0 ferr
//
// Ports:
//   avm_clk, avm_rst_n          clock, async active-low reset
//   avs_address/read/write/...  Avalon-MM slave, every access takes 2 cycles
//   uart_rxd                    serial in (asynchronous, synchronised here)
//   uart_txd                    serial out, registered, idle high
//
// Build option: define RS232_RX_FIFO_EN to replace the RX holding register
// with a 4-entry FIFO (rx_ok = not empty, a byte arriving when full is dropped
// and sets overrun).
module rs232_avalon_slave #(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 115200
) (
    input  logic        avm_clk,
    input  logic        avm_rst_n,
    input  logic [4:0]  avs_address,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic        avs_waitrequest,
    input  logic        uart_rxd,
    output logic        uart_txd
);
    localparam int DIV = CLK_HZ / BAUD;
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] CNT_TOP  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_TOP = CW'(DIV / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    // ---------------------------------------------------------------- bus
    logic ack_r, tx_ok, rx_ok, overrun, ferr;
    logic [7:0] rx_head;

    logic req, done, rd_done, wr_done, rx_pop, tx_wr;
    assign req     = avs_read | avs_write;
    assign done    = req & ack_r;
    assign rd_done = done & avs_read;
    assign wr_done = done & avs_write & ~avs_read;   // read wins if both
    assign rx_pop  = rd_done & (avs_address == 5'h0);
    assign tx_wr   = wr_done & (avs_address == 5'h4) & tx_ok;
    assign avs_waitrequest = ~done;

    logic unused_wdata;
    assign unused_wdata = ^avs_writedata[31:8];

    always_ff @(posedge avm_clk or negedge avm_rst_n) begin
        if (!avm_rst_n) begin
            ack_r        <= 1'b0;
            avs_readdata <= '0;
        end else begin
            if (done)     ack_r <= 1'b0;
            else if (req) ack_r <= 1'b1;
            // Data is captured in the first cycle, so a byte committing in
            // the completion cycle does not change what this read returns.
            if (req & ~ack_r & avs_read) begin
                case (avs_address)
                    5'h0:    avs_readdata <= {24'b0, rx_head};
                    5'h8:    avs_readdata <= {24'b0, rx_ok, tx_ok, 4'b0, overrun, ferr};
                    default: avs_readdata <= '0;
                endcase
            end
        end
    end

    // ---------------------------------------------------------------- RX
    logic rxd_m, rxd_s, rxd_d;
    rx_state_t rx_state, rx_next;
    logic [CW-1:0] rx_cnt;
    logic [2:0] rx_bit;
    logic [7:0] rx_shift;
    logic rx_tick, rx_half, rx_commit, rx_ferr_ev;

    assign rx_tick    = (rx_cnt == CNT_TOP);
    assign rx_half    = (rx_cnt == HALF_TOP);
    assign rx_commit  = (rx_state == RX_STOP) & rx_tick & rxd_s;
    assign rx_ferr_ev = (rx_state == RX_STOP) & rx_tick & ~rxd_s;

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (rxd_d & ~rxd_s)            rx_next = RX_START;
            RX_START: if (rx_half)                   rx_next = rxd_s ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_tick && rx_bit == 3'd7) rx_next = RX_STOP;
            RX_STOP:  if (rx_tick)                   rx_next = RX_IDLE;
            default:                                 rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge avm_clk or negedge avm_rst_n) begin
        if (!avm_rst_n) begin
            rxd_m    <= 1'b1;
            rxd_s    <= 1'b1;
            rxd_d    <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rxd_m    <= uart_rxd;
            rxd_s    <= rxd_m;
            rxd_d    <= rxd_s;
            rx_state <= rx_next;
            rx_cnt   <= (rx_state == RX_IDLE || rx_next != rx_state || rx_tick) ?
                        '0 : rx_cnt + 1'b1;
            if (rx_state == RX_START)
                rx_bit <= '0;
            else if (rx_state == RX_DATA && rx_tick) begin
                rx_bit   <= rx_bit + 1'b1;
                rx_shift <= {rxd_s, rx_shift[7:1]};   // LSB first
            end
        end
    end

`ifdef RS232_RX_FIFO_EN
    logic [7:0] fifo [4];
    logic [1:0] wp, rp;
    logic [2:0] fcnt;
    logic pop, push;
    assign pop     = rx_pop & (fcnt != 3'd0);
    // Pop frees a slot first, so a push into a full FIFO still succeeds.
    assign push    = rx_commit & ((fcnt != 3'd4) | pop);
    assign rx_ok   = (fcnt != 3'd0);
    assign rx_head = fifo[rp];

    always_ff @(posedge avm_clk)
        if (push) fifo[wp] <= rx_shift;

    always_ff @(posedge avm_clk or negedge avm_rst_n) begin
        if (!avm_rst_n) begin
            wp <= '0; rp <= '0; fcnt <= '0; overrun <= 1'b0; ferr <= 1'b0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop)  rp <= rp + 1'b1;
            case ({push, pop})
                2'b10:   fcnt <= fcnt + 1'b1;
                2'b01:   fcnt <= fcnt - 1'b1;
                default: ;
            endcase
            if (rx_commit & ~push) overrun <= 1'b1;
            else if (rx_pop)       overrun <= 1'b0;
            if (rx_ferr_ev)        ferr <= 1'b1;
            else if (rx_pop)       ferr <= 1'b0;
        end
    end
`else
    logic [7:0] rx_byte;
    assign rx_head = rx_byte;

    always_ff @(posedge avm_clk or negedge avm_rst_n) begin
        if (!avm_rst_n) begin
            rx_byte <= '0; rx_ok <= 1'b0; overrun <= 1'b0; ferr <= 1'b0;
        end else begin
            if (rx_commit) rx_byte <= rx_shift;
            // A commit in the read's completion cycle keeps rx_ok set: the
            // new byte has not been read yet.
            if (rx_commit)   rx_ok <= 1'b1;
            else if (rx_pop) rx_ok <= 1'b0;
            // Overwriting an unread byte is an overrun, unless that byte is
            // being consumed in this very cycle.
            if (rx_commit & rx_ok & ~rx_pop) overrun <= 1'b1;
            else if (rx_pop)                 overrun <= 1'b0;
            if (rx_ferr_ev)  ferr <= 1'b1;
            else if (rx_pop) ferr <= 1'b0;
        end
    end
`endif

    // ---------------------------------------------------------------- TX
    tx_state_t tx_state, tx_next;
    logic [CW-1:0] tx_cnt;
    logic [2:0] tx_bit;
    logic [7:0] tx_shift;
    logic tx_tick;

    assign tx_tick = (tx_cnt == CNT_TOP);

    // tx_ok low in IDLE means a byte was accepted and is waiting to go.
    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            TX_IDLE:  if (!tx_ok)                    tx_next = TX_START;
            TX_START: if (tx_tick)                   tx_next = TX_DATA;
            TX_DATA:  if (tx_tick && tx_bit == 3'd7) tx_next = TX_STOP;
            TX_STOP:  if (tx_tick)                   tx_next = TX_IDLE;
            default:                                 tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge avm_clk or negedge avm_rst_n) begin
        if (!avm_rst_n) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_ok    <= 1'b1;
            uart_txd <= 1'b1;
        end else begin
            tx_state <= tx_next;
            tx_cnt   <= (tx_state == TX_IDLE || tx_tick) ? '0 : tx_cnt + 1'b1;
            if (tx_wr)                                tx_ok <= 1'b0;
            else if (tx_state == TX_STOP && tx_tick)  tx_ok <= 1'b1;
            if (tx_wr) tx_shift <= avs_writedata[7:0];
            if (tx_state == TX_START) tx_bit <= '0;
            else if (tx_state == TX_DATA && tx_tick) tx_bit <= tx_bit + 1'b1;
            // Output is driven from the next state so each bit lasts exactly
            // DIV clocks; bit 0 of tx_shift is always the bit on the line.
            case (tx_next)
                TX_START: uart_txd <= 1'b0;
                TX_DATA: begin
                    if (tx_state == TX_DATA && tx_tick) begin
                        uart_txd <= tx_shift[1];
                        tx_shift <= {1'b0, tx_shift[7:1]};
                    end else begin
                        uart_txd <= tx_shift[0];
                    end
                end
                default:  uart_txd <= 1'b1;
            endcase
        end
    end
endmodule

// File: tb/tb_rs232_avalon_slave.sv
// tb_rs232_avalon_slave - scoreboard bench for rs232_avalon_slave, DIV=16.
// RX bytes are queued when a frame is driven and popped on RX reads; TX bytes
// are queued on a bus write and popped by a line monitor decoding uart_txd.
module tb_rs232_avalon_slave;
    logic        avm_clk = 1'b0;
    logic        avm_rst_n = 1'b0;
    logic [4:0]  avs_address = '0;
    logic        avs_read = 1'b0;
    logic [31:0] avs_readdata;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic        avs_waitrequest;
    logic        uart_rxd = 1'b1;
    logic        uart_txd;

    rs232_avalon_slave #(.CLK_HZ(16), .BAUD(1)) dut (
        .avm_clk(avm_clk), .avm_rst_n(avm_rst_n),
        .avs_address(avs_address), .avs_read(avs_read),
        .avs_readdata(avs_readdata), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_waitrequest(avs_waitrequest),
        .uart_rxd(uart_rxd), .uart_txd(uart_txd)
    );

    always #5 avm_clk = ~avm_clk;

    int n_tests = 0, n_fail = 0;
    int tx_frames = 0;
    bit mon_abort = 1'b0;
    logic [7:0] rx_q[$], tx_q[$];
    logic [31:0] d;
    int w;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge avm_clk);
        #1;
    endtask

    task automatic bus_rd(input logic [4:0] a, output logic [31:0] data, output int waits);
        avs_address = a; avs_read = 1'b1; waits = 0; data = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge avm_clk);
            if (!avs_waitrequest) begin data = avs_readdata; break; end
            waits++;
        end
        if (waits >= 20) chk("rd_timeout", 1, 0);
        @(posedge avm_clk); #1;
        avs_read = 1'b0;
    endtask

    task automatic bus_wr(input logic [4:0] a, input logic [31:0] data);
        int waits = 0;
        avs_address = a; avs_writedata = data; avs_write = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge avm_clk);
            if (!avs_waitrequest) break;
            waits++;
        end
        if (waits >= 20) chk("wr_timeout", 1, 0);
        @(posedge avm_clk); #1;
        avs_write = 1'b0;
    endtask

    task automatic status(input string tag, input logic [31:0] exp);
        logic [31:0] s;
        int ws;
        bus_rd(5'h8, s, ws);
        chk(tag, s, exp);
    endtask

    task automatic rx_read_chk(input string tag);
        logic [31:0] r;
        int ws;
        bus_rd(5'h0, r, ws);
        if (rx_q.size() == 0) chk({tag, "_noexp"}, 1, 0);
        else chk(tag, r, {24'b0, rx_q.pop_front()});
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        uart_rxd = 1'b0; clks(16);
        for (int i = 0; i < 8; i++) begin uart_rxd = b[i]; clks(16); end
        uart_rxd = stop_bit; clks(16);
        uart_rxd = 1'b1; clks(4);
    endtask

    always @(negedge avm_rst_n) mon_abort = 1'b1;

    // TX line monitor: samples mid-bit relative to the start edge.
    initial begin
        logic prev;
        logic s0, s1;
        logic [7:0] b;
        prev = 1'b1;
        forever begin
            @(negedge avm_clk);
            if (prev && !uart_txd && avm_rst_n) begin
                mon_abort = 1'b0;
                repeat (8) @(negedge avm_clk);
                s0 = uart_txd;
                for (int i = 0; i < 8; i++) begin
                    repeat (16) @(negedge avm_clk);
                    b[i] = uart_txd;
                end
                repeat (16) @(negedge avm_clk);
                s1 = uart_txd;
                if (!mon_abort) begin
                    tx_frames++;
                    chk("tx_start", s0, 0);
                    chk("tx_stop", s1, 1);
                    if (tx_q.size() == 0) chk("tx_unexpected", 1, 0);
                    else chk("tx_byte", b, tx_q.pop_front());
                end
            end
            prev = uart_txd;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        repeat (3) @(posedge avm_clk); #1;
        chk("rst_txd", uart_txd, 1);
        chk("rst_wait", avs_waitrequest, 1);
        chk("rst_rdata", avs_readdata, 0);
        avm_rst_n = 1'b1; clks(2);
        bus_rd(5'h8, d, w);
        chk("stat_rst", d, 32'h40);
        chk("stat_waits", w, 1);
        chk("idle_txd", uart_txd, 1);

        // single RX byte
        rx_q.push_back(8'hA5); send_rx(8'hA5, 1'b1);
        status("stat_rx_full", 32'hC0);
        rx_read_chk("rx_a5");
        status("stat_rx_empty", 32'h40);

        // TX frame, second write mid-frame must be dropped
        tx_q.push_back(8'h3C); bus_wr(5'h4, 32'h3C);
        clks(2);
        status("stat_tx_busy", 32'h00);
        clks(60);
        bus_wr(5'h4, 32'hFF);
        clks(120);
        status("stat_tx_done", 32'h40);
        clks(300);
        chk("tx_frames", tx_frames, 1);
        chk("tx_q_empty", tx_q.size(), 0);

        // two bytes without a read
`ifdef RS232_RX_FIFO_EN
        rx_q.push_back(8'h11); rx_q.push_back(8'h22);
`else
        rx_q.push_back(8'h22);
`endif
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
`ifdef RS232_RX_FIFO_EN
        status("stat_two", 32'hC0);
        rx_read_chk("rx_11");
        rx_read_chk("rx_22");
`else
        status("stat_overrun", 32'hC2);
        rx_read_chk("rx_22");
`endif
        status("stat_after_two", 32'h40);

        // framing error, then a short glitch
        send_rx(8'h55, 1'b0);
        status("stat_ferr", 32'h41);
        uart_rxd = 1'b0; clks(8); uart_rxd = 1'b1; clks(200);
        status("stat_glitch", 32'h41);
        bus_rd(5'h0, d, w);
        status("stat_ferr_clr", 32'h40);

        // reset in the middle of a TX frame
        bus_wr(5'h4, 32'hF0);
        clks(40);
        chk("pre_rst_txd", uart_txd, 0);
        avm_rst_n = 1'b0; #1;
        chk("mid_rst_txd", uart_txd, 1);
        chk("mid_rst_wait", avs_waitrequest, 1);
        repeat (3) @(posedge avm_clk); #1;
        avm_rst_n = 1'b1; clks(2);
        status("stat_post_rst", 32'h40);
        clks(200);

        // normal operation resumes
        tx_q.push_back(8'h81); bus_wr(5'h4, 32'h81);
        rx_q.push_back(8'h7E); send_rx(8'h7E, 1'b1);
        clks(200);
        rx_read_chk("rx_7e");
        chk("tx_frames_end", tx_frames, 2);
        chk("tx_q_end", tx_q.size(), 0);
        chk("rx_q_end", rx_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/rs232_avalon_slave.md
Name: rs232_avalon_slave

Overview:
- Avalon-MM slave UART that sits directly upstream of the RSA wrapper. The wrapper polls its STATUS register, reads key and ciphertext bytes from RX, and writes decrypted bytes to TX.
- It serialises and deserialises 8N1 RS-232 frames on the board pins.
- Register map: RX @0x0, TX @0x4, STATUS @0x8. TX_OK is STATUS bit 6; RX_OK is STATUS bit 7.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- BAUD, 115200, line rate. DIV = CLK_HZ/BAUD is the clocks per bit; DIV must be at least 4.

Ports:
- avm_clk  in  1  system clock; all logic on rising edge.
- avm_rst_n  in  1  asynchronous, active-low reset.
- avs_address  in  5  byte address; only 0x0/0x4/0x8 decode, others read 0 and ignore writes.
- avs_read  in  1  read request, held by master until waitrequest low.
- avs_readdata  out  32  read data, valid in the cycle waitrequest is low.
- avs_write  in  1  write request, held until waitrequest low.
- avs_writedata  in  32  write data; only bits [7:0] used.
- avs_waitrequest  out  1  stall; transfer completes in the cycle it is low.
- uart_rxd  in  1  serial input, asynchronous to avm_clk.
- uart_txd  out  1  serial output, idle high.

Behaviour:
- Reset values:
  - avs_readdata=0, avs_waitrequest=1, uart_txd=1.
  - rx_ok=0, tx_ok=1, overrun=0, ferr=0; both FSMs in IDLE.
- Bus handshake:
  - ack_r flop; avs_waitrequest = ~((avs_read|avs_write) & ack_r) when a request is present, and 1 when idle.
  - Cycle 1 of a request: ack_r<=1 and avs_readdata registered. Cycle 2: waitrequest=0, transfer completes, ack_r<=0.
  - Every access is exactly 2 cycles. Read and write asserted together: the read is serviced and the write is ignored.
- RX read (addr 0): readdata={24'b0, rx_byte}; rx_ok cleared on completion; overrun and ferr cleared on completion.
- TX write (addr 4):
  - If tx_ok=1: latch [7:0], tx_ok<=0, TX FSM leaves IDLE next cycle.
  - If tx_ok=0: data dropped; the transfer still completes normally.
- STATUS read (addr 8): bit7=rx_ok, bit6=tx_ok, bit1=overrun, bit0=ferr, all others 0. A STATUS read has no side effects.
- RX path:
  - Two-flop synchroniser on uart_rxd.
  - FSM IDLE -> START on a falling edge. START waits DIV/2 clocks, then returns to IDLE if the line is high (glitch) or goes to DATA if it is low.
  - DATA samples 8 bits LSB-first, one every DIV clocks. STOP samples after DIV clocks.
  - Stop bit 1: rx_byte<=shift, rx_ok<=1; if rx_ok was already 1, overrun<=1 and the new byte overwrites.
  - Stop bit 0: byte discarded, ferr<=1.
  - FSM returns to IDLE in the cycle after the stop sample.
- TX path:
  - FSM IDLE -> START (txd=0 for DIV clocks) -> DATA (8 bits LSB-first, DIV each) -> STOP (txd=1 for DIV clocks) -> IDLE, with tx_ok<=1 on entering IDLE.
  - uart_txd is registered, so it is glitch-free.
- Simultaneous events:
  - RX read completing in the same cycle a new byte commits: the new byte wins, rx_ok stays 1, and the read returns the old byte.
  - TX write completing in the same cycle STOP ends: tx_ok is already 0 because the write sees the pre-edge value, so the write is dropped.
- Baud counters count 0..DIV-1 and wrap; the width is $clog2(DIV).
- Reset mid-frame: uart_txd is forced high immediately, the partial RX byte is lost, and any in-flight bus transfer is aborted with waitrequest=1.

Optional Feature:
- Macro RS232_RX_FIFO_EN.
- Defined:
  - The RX holding register is replaced by a 4-entry FIFO; rx_ok = FIFO not empty.
  - An RX read pops the head.
  - A byte arriving when the FIFO is full is dropped and sets overrun; the stored contents are unchanged.
  - Simultaneous push and pop on a full FIFO: the pop happens first and the push succeeds.
- Undefined: a single holding register with the overwrite semantics above.

Test Plan:
- Reset, then STATUS read -> avs_waitrequest high 1 cycle, readdata=0x00000040, uart_txd=1.
- CLK_HZ=16, BAUD=1 (DIV=16): drive RX frame for 0xA5 -> STATUS=0x000000C0; RX read returns 0x000000A5; next STATUS=0x00000040.
- TX write 0x3C -> txd low 16 clocks, then bits 0,0,1,1,1,1,0,0 at 16 clocks each, then high 16 clocks; STATUS bit6=0 during the frame and 1 after. A second write mid-frame is dropped, with no second frame.
- Two RX frames 0x11, 0x22 without a read -> RX read returns 0x22 and STATUS shows overrun (bit1=1). With RS232_RX_FIFO_EN: reads return 0x11 then 0x22, and no overrun.
- RX frame with stop bit 0 -> rx_ok stays 0, STATUS bit0=1. An 8-clock low glitch on rxd produces no byte.
- Assert avm_rst_n low mid-TX-frame -> uart_txd=1 immediately; after release, STATUS=0x00000040 and normal operation resumes.
